// File: rtl/fwd_haz_pkg.sv
// Shared constants for the forwarding / hazard unit: operand-mux select codes
// and the default register-file geometry.
package fwd_haz_pkg;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_NUM_REGS   = 32;

endpackage

// File: rtl/fwd_haz_scoreboard.sv
// Register scoreboard for the multi-cycle unit: one pending bit per register
// plus a saturating outstanding-op counter and the busy flag derived from it.
import fwd_haz_pkg::*;

module fwd_haz_scoreboard #(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int MC_MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic [REG_ADDR_W-1:0] issueRd,
    input  logic                  retire,
    input  logic [REG_ADDR_W-1:0] retireRd,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MC_MAX_OUT + 1);

    logic [NUM_REGS-1:0] pendingR;
    logic [NUM_REGS-1:0] pendingNextS;
    logic [CNT_W-1:0]    outCntR;
    logic [CNT_W-1:0]    outCntNextS;
    logic                decS;

    // Next pending vector: a same-cycle set beats the clear (new producer); r0 never pends.
    always_comb begin
        pendingNextS = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            pendingNextS[i] = (issue && (issueRd == REG_ADDR_W'(i))) ||
                              (pendingR[i] && !(retire && (retireRd == REG_ADDR_W'(i))));
        end
    end

    // Next outstanding count; retire at zero is ignored so the counter saturates.
    always_comb begin
        decS        = retire && (outCntR != {CNT_W{1'b0}});
        outCntNextS = outCntR;
        case ({issue, decS})
            2'b10:   outCntNextS = outCntR + CNT_W'(1);
            2'b01:   outCntNextS = outCntR - CNT_W'(1);
            default: outCntNextS = outCntR;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendingR <= {NUM_REGS{1'b0}};
            outCntR  <= {CNT_W{1'b0}};
        end else begin
            pendingR <= pendingNextS;
            outCntR  <= outCntNextS;
        end
    end

    assign pending = pendingR;
    assign busy    = (outCntR == CNT_W'(MC_MAX_OUT));

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, load-use / scoreboard / structural stall generation.
// Optional stall-cycle performance counter enabled by FWD_HAZ_PERF_CNT_EN.
import fwd_haz_pkg::*;

module fwd_hazard_unit #(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int NUM_SRC    = 2,
    parameter int MC_MAX_OUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_mc_issue,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs,
    input  logic [REG_ADDR_W-1:0]         id_ex_rd,
    input  logic                          id_ex_memread,
    input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
    input  logic                          ex_mem_regwrite,
    input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
    input  logic                          mem_wb_regwrite,
    input  logic                          mc_done,
    input  logic [REG_ADDR_W-1:0]         mc_done_rd,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          mc_busy,
    output logic [31:0]                   perf_stall_cnt
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    logic [2*NUM_SRC-1:0] fwdSelS;
    logic [NUM_REGS-1:0]  pendingS;
    logic                 mcBusyS;
    logic                 loadUseS;
    logic                 rawS;
    logic                 wawS;
    logic                 structS;
    logic                 stallS;
    logic                 issueS;

    // Per-source forwarding select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwdSelS = {2*NUM_SRC{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_mem_regwrite && (ex_mem_rd != REG_ZERO) &&
                (ex_mem_rd == id_ex_rs[k*REG_ADDR_W +: REG_ADDR_W])) begin
                fwdSelS[2*k +: 2] = FWD_EX_MEM;
            end else if (mem_wb_regwrite && (mem_wb_rd != REG_ZERO) &&
                         (mem_wb_rd == id_ex_rs[k*REG_ADDR_W +: REG_ADDR_W])) begin
                fwdSelS[2*k +: 2] = FWD_MEM_WB;
            end else begin
                fwdSelS[2*k +: 2] = FWD_NONE;
            end
        end
    end

    // Stall sources; a result retiring this cycle is bypassed, so it does not stall.
    always_comb begin
        loadUseS = 1'b0;
        rawS     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used[k] && (id_rs[k*REG_ADDR_W +: REG_ADDR_W] != REG_ZERO)) begin
                loadUseS = loadUseS ||
                           (id_ex_memread && (id_ex_rd == id_rs[k*REG_ADDR_W +: REG_ADDR_W]));
                rawS     = rawS ||
                           (pendingS[id_rs[k*REG_ADDR_W +: REG_ADDR_W]] &&
                            !(mc_done && (mc_done_rd == id_rs[k*REG_ADDR_W +: REG_ADDR_W])));
            end else begin
                loadUseS = loadUseS;
                rawS     = rawS;
            end
        end
        wawS    = id_regwrite && (id_rd != REG_ZERO) && pendingS[id_rd] &&
                  !(mc_done && (mc_done_rd == id_rd));
        structS = id_mc_issue && mcBusyS;
        stallS  = loadUseS || rawS || wawS || structS;
        issueS  = id_mc_issue && id_regwrite && !stallS;
    end

    fwd_haz_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .MC_MAX_OUT (MC_MAX_OUT)
    ) uScoreboard (
        .clk      (clk),
        .rst      (rst),
        .issue    (issueS),
        .issueRd  (id_rd),
        .retire   (mc_done),
        .retireRd (mc_done_rd),
        .pending  (pendingS),
        .busy     (mcBusyS)
    );

`ifdef FWD_HAZ_PERF_CNT_EN
    logic [31:0] perfCntR;

    // Free-running stall-cycle counter, wraps naturally at 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfCntR <= 32'd0;
        end else if (stallS) begin
            perfCntR <= perfCntR + 32'd1;
        end else begin
            perfCntR <= perfCntR;
        end
    end

    assign perf_stall_cnt = perfCntR;
`else
    assign perf_stall_cnt = 32'd0;
`endif

    assign fwd_sel = fwdSelS;
    assign stall   = stallS;
    assign mc_busy = mcBusyS;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: table of combinational forwarding /
// load-use vectors followed by hand-written scoreboard and reset sequences.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_mc_issue;
    logic [9:0]  id_ex_rs;
    logic [4:0]  id_ex_rd;
    logic        id_ex_memread;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_regwrite;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite;
    logic        mc_done;
    logic [4:0]  mc_done_rd;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        mc_busy;
    logic [31:0] perf_stall_cnt;

    int nTests = 0;
    int nFail  = 0;

    fwd_hazard_unit u_dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_mc_issue     (id_mc_issue),
        .id_ex_rs        (id_ex_rs),
        .id_ex_rd        (id_ex_rd),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mc_done         (mc_done),
        .mc_done_rd      (mc_done_rd),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .mc_busy         (mc_busy),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] idRs;
        logic [1:0] used;
        logic [9:0] idExRs;
        logic [4:0] exMemRd;
        logic       exMemWr;
        logic [4:0] memWbRd;
        logic       memWbWr;
        logic       memRead;
        logic [4:0] idExRd;
        logic [3:0] expFwd;
        logic       expStall;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        id_rs = 10'd0; id_rs_used = 2'b00; id_rd = 5'd0; id_regwrite = 1'b0;
        id_mc_issue = 1'b0; id_ex_rs = 10'd0; id_ex_rd = 5'd0; id_ex_memread = 1'b0;
        ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b0; mem_wb_rd = 5'd0; mem_wb_regwrite = 1'b0;
        mc_done = 1'b0; mc_done_rd = 5'd0;
    endtask

    logic [31:0] expPerf;

    initial begin
        //            idRs               used   idExRs             exm   w     mwb   w     ld    idExRd fwd      stall
        vecs[0]  = '{{5'd0, 5'd0},  2'b00, {5'd0, 5'd5},   5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 4'b0010, 1'b0};
        vecs[1]  = '{{5'd0, 5'd0},  2'b00, {5'd0, 5'd5},   5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 4'b0001, 1'b0};
        vecs[2]  = '{{5'd0, 5'd0},  2'b00, {5'd0, 5'd0},   5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0};
        vecs[3]  = '{{5'd0, 5'd0},  2'b00, {5'd4, 5'd3},   5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 4'b0110, 1'b0};
        vecs[4]  = '{{5'd0, 5'd0},  2'b00, {5'd3, 5'd3},   5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 4'b1010, 1'b0};
        vecs[5]  = '{{5'd0, 5'd0},  2'b00, {5'd31, 5'd31}, 5'd30, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 4'b0101, 1'b0};
        vecs[6]  = '{{5'd7, 5'd2},  2'b11, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 4'b0000, 1'b1};
        vecs[7]  = '{{5'd7, 5'd2},  2'b01, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 4'b0000, 1'b0};
        vecs[8]  = '{{5'd0, 5'd0},  2'b11, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 4'b0000, 1'b0};
        vecs[9]  = '{{5'd7, 5'd7},  2'b11, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 4'b0000, 1'b0};
        vecs[10] = '{{5'd3, 5'd12}, 2'b01, {5'd0, 5'd0},   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 4'b0000, 1'b1};

`ifdef FWD_HAZ_PERF_CNT_EN
        expPerf = 32'd10;
`else
        expPerf = 32'd0;
`endif

        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(mc_busy), 32'd0);
        check("rst_perf", perf_stall_cnt, 32'd0);
        check("rst_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd0);
        check("rst_pend", u_dut.uScoreboard.pendingR, 32'd0);
        rst = 1'b0;

        // Combinational table
        for (int i = 0; i < 11; i++) begin
            tick();
            id_rs = vecs[i].idRs; id_rs_used = vecs[i].used; id_ex_rs = vecs[i].idExRs;
            ex_mem_rd = vecs[i].exMemRd; ex_mem_regwrite = vecs[i].exMemWr;
            mem_wb_rd = vecs[i].memWbRd; mem_wb_regwrite = vecs[i].memWbWr;
            id_ex_memread = vecs[i].memRead; id_ex_rd = vecs[i].idExRd;
            #1;
            check($sformatf("vec%0d_fwd", i), 32'(fwd_sel), 32'(vecs[i].expFwd));
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
        end
        tick();
        clearInputs();

        // RAW on scoreboard for r9
        tick(); id_mc_issue = 1'b1; id_regwrite = 1'b1; id_rd = 5'd9; #1;
        check("issue9_stall", 32'(stall), 32'd0);
        tick(); id_mc_issue = 1'b0; id_regwrite = 1'b0; id_rd = 5'd0;
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01; #1;
        check("pend9_set", 32'(u_dut.uScoreboard.pendingR[9]), 32'd1);
        check("cnt_1", 32'(u_dut.uScoreboard.outCntR), 32'd1);
        check("raw9_c0", 32'(stall), 32'd1);
        for (int c = 1; c < 3; c++) begin
            tick(); #1;
            check($sformatf("raw9_c%0d", c), 32'(stall), 32'd1);
        end
        tick(); id_regwrite = 1'b1; id_rd = 5'd9; id_rs_used = 2'b00; #1;
        check("waw9", 32'(stall), 32'd1);
        tick(); id_regwrite = 1'b0; id_rd = 5'd0; id_rs_used = 2'b01;
        mc_done = 1'b1; mc_done_rd = 5'd9; #1;
        check("retire9_stall", 32'(stall), 32'd0);
        tick(); mc_done = 1'b0; #1;
        check("pend9_clr", 32'(u_dut.uScoreboard.pendingR[9]), 32'd0);
        check("cnt_0", 32'(u_dut.uScoreboard.outCntR), 32'd0);
        check("after9_stall", 32'(stall), 32'd0);
        id_rs_used = 2'b00; id_rs = 10'd0;

        // Fill to MC_MAX_OUT
        for (int r = 1; r <= 4; r++) begin
            tick(); id_mc_issue = 1'b1; id_regwrite = 1'b1; id_rd = 5'(r); #1;
            check($sformatf("fill%0d_stall", r), 32'(stall), 32'd0);
        end
        tick(); id_rd = 5'd5; #1;
        check("full_busy", 32'(mc_busy), 32'd1);
        check("full_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd4);
        check("struct_stall", 32'(stall), 32'd1);
        tick(); id_mc_issue = 1'b0; id_regwrite = 1'b0; id_rd = 5'd0;
        mc_done = 1'b1; mc_done_rd = 5'd1; #1;
        check("blocked_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd4);
        check("blocked_pend5", 32'(u_dut.uScoreboard.pendingR[5]), 32'd0);
        tick(); mc_done = 1'b0; #1;
        check("unbusy", 32'(mc_busy), 32'd0);
        check("cnt_3", 32'(u_dut.uScoreboard.outCntR), 32'd3);

        // Same-cycle issue and retire of r3, then issue with rd=0
        tick(); id_mc_issue = 1'b1; id_regwrite = 1'b1; id_rd = 5'd3;
        mc_done = 1'b1; mc_done_rd = 5'd3; #1;
        check("same3_stall", 32'(stall), 32'd0);
        tick(); id_rd = 5'd0; mc_done = 1'b0; #1;
        check("same3_pend", 32'(u_dut.uScoreboard.pendingR[3]), 32'd1);
        check("same3_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd3);
        tick(); id_mc_issue = 1'b0; id_regwrite = 1'b0; #1;
        check("rd0_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd4);
        check("rd0_busy", 32'(mc_busy), 32'd1);
        tick(); mc_done = 1'b1; mc_done_rd = 5'd2;
        tick(); mc_done_rd = 5'd4;
        tick(); mc_done = 1'b0; #1;
        check("two_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd2);
        check("two_pend", u_dut.uScoreboard.pendingR, 32'h0000_0008);

        // Asynchronous reset mid-cycle with ops outstanding
        #2;
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
        rst = 1'b1; #1;
        check("arst_pend", u_dut.uScoreboard.pendingR, 32'd0);
        check("arst_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd0);
        check("arst_busy", 32'(mc_busy), 32'd0);
        check("arst_perf", perf_stall_cnt, 32'd0);
        check("arst_stall", 32'(stall), 32'd1);
        tick(); rst = 1'b0; id_ex_memread = 1'b0; id_rs_used = 2'b00; #1;
        check("post_rst_stall", 32'(stall), 32'd0);

        // Retire with nothing outstanding saturates at zero
        tick(); mc_done = 1'b1; mc_done_rd = 5'd7;
        tick(); mc_done = 1'b0; #1;
        check("sat_cnt", 32'(u_dut.uScoreboard.outCntR), 32'd0);
        check("sat_busy", 32'(mc_busy), 32'd0);

        // Ten stall cycles for the performance counter
        check("perf_start", perf_stall_cnt, 32'd0);
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
        repeat (10) @(posedge clk);
        #1; id_ex_memread = 1'b0; id_rs_used = 2'b00; #1;
        check("perf_10", perf_stall_cnt, expPerf);
        rst = 1'b1; #1;
        check("perf_rst", perf_stall_cnt, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-operand EX-stage forwarding unit.
- Generalises forwarding to NUM_SRC source operands and adds load-use stall detection.
- Adds a register scoreboard for a variable-latency multi-cycle unit (mul/div), which writes back through MEM/WB.
- Sits between ID and EX: drives EX operand mux selects and the global stall (freeze PC and IF/ID, bubble into ID/EX).

Parameters:
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural registers (2**REG_ADDR_W); register 0 is hard-wired zero.
- NUM_SRC, 2, source operands per instruction (1..3).
- MC_MAX_OUT, 4, maximum outstanding multi-cycle ops.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  NUM_SRC*REG_ADDR_W  ID-stage source indices, src k at [k*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_SRC  ID source k actually read
- id_rd  in  REG_ADDR_W  ID-stage destination
- id_regwrite  in  1  ID instruction writes id_rd
- id_mc_issue  in  1  ID instruction is a multi-cycle op
- id_ex_rs  in  NUM_SRC*REG_ADDR_W  EX-stage source indices
- id_ex_rd  in  REG_ADDR_W  EX-stage destination
- id_ex_memread  in  1  EX instruction is a load
- ex_mem_rd  in  REG_ADDR_W  MEM-stage destination
- ex_mem_regwrite  in  1  MEM-stage write enable
- mem_wb_rd  in  REG_ADDR_W  WB-stage destination
- mem_wb_regwrite  in  1  WB-stage write enable
- mc_done  in  1  multi-cycle result retiring this cycle
- mc_done_rd  in  REG_ADDR_W  destination of retiring result
- fwd_sel  out  2*NUM_SRC  per EX source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall  out  1  hold IF/ID and PC, insert bubble
- mc_busy  out  1  outstanding count == MC_MAX_OUT
- perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Forwarding is combinational per source k:
  - 10 if ex_mem_regwrite, ex_mem_rd != 0 and ex_mem_rd == id_ex_rs[k].
  - Else 01 if mem_wb_regwrite, mem_wb_rd != 0 and mem_wb_rd == id_ex_rs[k].
  - Else 00.
  - EX/MEM always wins when both stages match.
- Scoreboard: pending[NUM_REGS-1:0] plus outstanding counter out_cnt (width clog2(MC_MAX_OUT+1)), both registered.
- Effective issue: iss = id_mc_issue & id_regwrite & ~stall.
  - On iss with id_rd != 0: pending[id_rd] set next cycle.
  - On iss: out_cnt increments, including when id_rd == 0.
- Retire: on mc_done, pending[mc_done_rd] cleared and out_cnt decrements.
- Same-cycle iss and mc_done:
  - Same register: the set wins (new producer).
  - Counter: net change 0.
- mc_done with out_cnt == 0: counter holds at 0 (saturating); pending bit is still cleared.
- stall (combinational from current state and inputs) is the OR of:
  - Load-use: id_ex_memread, id_ex_rd != 0, id_ex_rd == id_rs[k] with id_rs_used[k].
  - RAW on scoreboard: pending[id_rs[k]] with id_rs_used[k], id_rs[k] != 0, not retiring this cycle (mc_done & mc_done_rd == id_rs[k]).
  - WAW: id_regwrite, id_rd != 0, pending[id_rd], not retiring this cycle.
  - Structural: id_mc_issue and mc_busy.
- mc_busy = (out_cnt == MC_MAX_OUT).
- Reset (asynchronous, any time including with ops in flight):
  - pending = 0, out_cnt = 0, mc_busy = 0, perf_stall_cnt = 0.
  - stall and fwd_sel follow their combinational inputs immediately.
- Latency:
  - Forwarding and stall are 0 cycles.
  - Scoreboard updates are visible the cycle after the issue or retire edge.

Optional Feature:
- Macro FWD_HAZ_PERF_CNT_EN.
- Defined: perf_stall_cnt increments by 1 on every clk edge where stall == 1; wraps at 2**32; cleared by rst.
- Undefined: perf_stall_cnt tied to 0; no counter flops.

Decomposition:
- Package fwd_haz_pkg holds FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, and the default REG_ADDR_W/NUM_REGS constants.
- One sub-module, fwd_haz_scoreboard: pending vector, out_cnt, set/clear priority, busy flag.
- Forwarding compare and stall OR-reduction stay in the top.

Test Plan:
- ex_mem_rd=5 regwrite=1, mem_wb_rd=5 regwrite=1, id_ex_rs[0]=5 -> fwd_sel[1:0]=10; then ex_mem_regwrite=0 -> 01; ex_mem_rd=0 with id_ex_rs[0]=0 -> 00.
- Load-use: id_ex_memread=1 id_ex_rd=7, id_rs[1]=7 used=1 -> stall=1; same with id_rs_used[1]=0 -> stall=0.
- Issue MC op rd=9, then ID reads r9 -> stall=1 each cycle until mc_done mc_done_rd=9; stall drops in the retire cycle; pending[9]=0 next cycle.
- Issue 4 MC ops with no retires -> mc_busy=1; fifth id_mc_issue -> stall=1 and out_cnt stays 4; one mc_done -> mc_busy=0 next cycle.
- Same-cycle issue rd=3 and mc_done rd=3 -> pending[3]=1 afterwards; out_cnt unchanged.
- Assert rst with 2 ops outstanding -> pending=0, out_cnt=0, mc_busy=0 immediately; with FWD_HAZ_PERF_CNT_EN, 10 stall cycles -> perf_stall_cnt=10, and 0 after rst.
